// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
// Optional right-shift support is built when SHIFT_SEQ_RIGHT_EN is defined.
package shift_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AMT_W_DEF  = 5;
    localparam int STEP_W_DEF = 4;
    localparam int STEP_MAX   = (1 << STEP_W_DEF) - 1;

    // req_op[0]: operation kind, req_op[1]: direction
    localparam logic OP_LOG = 1'b0;
    localparam logic OP_ROT = 1'b1;
    localparam logic DIR_L  = 1'b0;
    localparam logic DIR_R  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift pass of at most 2**STEP_W-1 positions.
// The operand is doubled so that one shifter yields both the rotate
// (wrapped half) and the logical (zero-filled half) result.
// Direction input exists only when SHIFT_SEQ_RIGHT_EN is defined.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    input  logic [STEP_W-1:0] amt,
    input  logic              rotate,
`ifdef SHIFT_SEQ_RIGHT_EN
    input  logic              dir,
`endif
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] dbl_left;
`ifdef SHIFT_SEQ_RIGHT_EN
    logic [2*DATA_W-1:0] dbl_right;
`endif

    // Pick the wrapped or zero-filled half of the doubled shift
    always_comb begin
        dbl_left = {data, data} << amt;
        result   = rotate ? dbl_left[2*DATA_W-1:DATA_W] : dbl_left[DATA_W-1:0];
`ifdef SHIFT_SEQ_RIGHT_EN
        dbl_right = {data, data} >> amt;
        if (dir == DIR_R) begin
            result = rotate ? dbl_right[DATA_W-1:0] : dbl_right[2*DATA_W-1:DATA_W];
        end
`endif
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: accepts a full-width shift request, applies it in
// passes of up to 2**STEP_W-1 positions through one shift_step, and
// returns the result over a valid/ready response channel.
// Right shifts/rotates are available when SHIFT_SEQ_RIGHT_EN is defined;
// otherwise req_op[1] is ignored and every operation is a left shift.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   RUN   | one shift pass per cycle until remaining reaches zero
//   DONE  | result presented, waiting for resp_ready
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AMT_W-1:0]  req_amt,
    input  logic [1:0]        req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam int STEP_LIM = (1 << STEP_W) - 1;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [AMT_W-1:0]  remaining;
    logic [AMT_W-1:0]  remaining_next;
    logic [STEP_W-1:0] step_amt;
    logic [DATA_W-1:0] step_out;
    logic              op_rot;
`ifdef SHIFT_SEQ_RIGHT_EN
    logic              op_dir;
`else
    logic              unused_op_dir;
    assign unused_op_dir = req_op[1];
`endif

    assign req_ready = (state == IDLE) && !rst;

    // Clamp each pass to the step limit; the down-counter ends at zero
    always_comb begin
        step_amt = (remaining > AMT_W'(STEP_LIM)) ? STEP_W'(STEP_LIM)
                                                  : remaining[STEP_W-1:0];
        remaining_next = remaining - AMT_W'(step_amt);
    end

    shift_step #(
        .DATA_W (DATA_W),
        .STEP_W (STEP_W)
    ) u_step (
        .data   (acc),
        .amt    (step_amt),
        .rotate (op_rot),
`ifdef SHIFT_SEQ_RIGHT_EN
        .dir    (op_dir),
`endif
        .result (step_out)
    );

    // Sequencer FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            remaining  <= '0;
            op_rot     <= 1'b0;
`ifdef SHIFT_SEQ_RIGHT_EN
            op_dir     <= DIR_L;
`endif
            resp_valid <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        acc       <= req_data;
                        remaining <= req_amt;
                        op_rot    <= (req_op[0] == OP_ROT);
`ifdef SHIFT_SEQ_RIGHT_EN
                        op_dir    <= req_op[1];
`endif
                        busy      <= 1'b1;
                        if (req_amt == '0) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= req_data;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc       <= step_out;
                    remaining <= remaining_next;
                    if (remaining_next == '0) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= step_out;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
